thor2023_dcache_wr_arb: RTL and testbench

//  Arbitrates the single write port of the data cache between line fills, store-hit updates and invalidates.

---
 rtl/thor2023_cache_pkg.sv | 19 +
 rtl/thor2023_dcache_inv_sweep.sv | 25 ++
 rtl/thor2023_dcache_wr_arb.sv | 216 +++++++++++++++++++++
 tb/tb_thor2023_dcache_wr_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thor2023_cache_pkg.sv
// Shared types for the dcache write-port arbiter.
package thor2023_cache_pkg;

    localparam int unsigned STARVE_DEF = 7;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SWEEP
    } dcwr_state_t;

    typedef enum logic [1:0] {
        NONE,
        FILL,
        STORE,
        INV
    } dcwr_src_t;

endpackage

// File: rtl/thor2023_dcache_inv_sweep.sv
// Set counter for full-cache invalidate sweeps.
module thor2023_dcache_inv_sweep #(
    parameter int unsigned SETS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adv,
    output logic [$clog2(SETS)-1:0] cnt,
    output logic                    last_c
);

    localparam int unsigned SW = $clog2(SETS);

    // Advance one set per swept cycle; holds while a fill/store preempts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= cnt + SW'(1);
        end
    end

    assign last_c = (cnt == SW'(SETS - 1));

endmodule

// File: rtl/thor2023_dcache_wr_arb.sv
// Arbitrates the dcache write port between line fills, store updates and invalidates.
module thor2023_dcache_wr_arb
    import thor2023_cache_pkg::*;
#(
    parameter int unsigned WID    = 768,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned SETS   = 64,
    parameter int unsigned LOBIT  = 7,
    parameter int unsigned STARVE = STARVE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fill_req,
    input  logic [31:0]             fill_adr,
    input  logic [$clog2(WAYS)-1:0] fill_way,
    input  logic [WID-1:0]          fill_dat,
    output logic                    fill_ack,
    input  logic                    st_req,
    input  logic [31:0]             st_adr,
    input  logic [$clog2(WAYS)-1:0] st_way,
    input  logic                    st_hit,
    input  logic [3:0]              st_acr,
    input  logic [WID/8-1:0]        st_sel,
    input  logic [WID-1:0]          st_dat,
    output logic                    st_ack,
    output logic                    st_retry,
    input  logic                    inv_req,
    input  logic                    inv_all,
    input  logic [31:0]             inv_adr,
    output logic                    inv_ack,
    output logic                    wr,
    output logic                    tag_wr,
    output logic                    tag_v,
    output logic [WAYS-1:0]         wr_way,
    output logic [$clog2(SETS)-1:0] wr_set,
    output logic [WID/8-1:0]        wr_sel,
    output logic [WID-1:0]          wr_dat
);

    localparam int unsigned SW = $clog2(SETS);
    localparam int unsigned BW = WID / 8;
    localparam int unsigned CW = $clog2(STARVE + 1);

    dcwr_state_t   state, state_nx;
    dcwr_src_t     win;
    logic [CW-1:0] starve_cnt, starve_nx;
    logic          hazard, hazard_nx;
    logic          fill_pend, st_pend, inv_pend, promote;
    logic [SW-1:0] fill_set, st_set, inv_set, sweep_set;
    logic          sweep_adv, sweep_last_c;

    logic            fill_ack_nx, st_ack_nx, st_retry_nx, inv_ack_nx;
    logic            wr_nx, tag_wr_nx, tag_v_nx;
    logic [WAYS-1:0] wr_way_nx;
    logic [SW-1:0]   wr_set_nx;
    logic [BW-1:0]   wr_sel_nx;
    logic [WID-1:0]  wr_dat_nx;

    logic unused_bits;
    assign unused_bits = ^{fill_adr, st_adr, inv_adr, st_acr};

    assign fill_set = fill_adr[LOBIT +: SW];
    assign st_set   = st_adr[LOBIT +: SW];
    assign inv_set  = inv_adr[LOBIT +: SW];

    thor2023_dcache_inv_sweep #(
        .SETS (SETS)
    ) u_sweep (
        .clk    (clk),
        .rst    (rst),
        .adv    (sweep_adv),
        .cnt    (sweep_set),
        .last_c (sweep_last_c)
    );

    // Pick the winner; a request whose ack is showing this cycle is the one just served.
    always_comb begin
        fill_pend = fill_req & ~fill_ack;
        st_pend   = st_req & ~st_ack;
        inv_pend  = inv_req & ~inv_ack & (state != SWEEP);
        promote   = (starve_cnt == CW'(STARVE));
        win       = NONE;
        if (st_pend && (promote || !fill_pend)) begin
            win = STORE;
        end else if (fill_pend) begin
            win = FILL;
        end else if (inv_pend) begin
            win = INV;
        end
    end

    // Next state, next registered outputs, starvation and retry-hazard tracking.
    always_comb begin
        state_nx    = state;
        starve_nx   = starve_cnt;
        hazard_nx   = hazard;
        sweep_adv   = 1'b0;
        fill_ack_nx = 1'b0;
        st_ack_nx   = 1'b0;
        st_retry_nx = 1'b0;
        inv_ack_nx  = 1'b0;
        wr_nx       = 1'b0;
        tag_wr_nx   = 1'b0;
        tag_v_nx    = 1'b0;
        wr_way_nx   = '0;
        wr_set_nx   = '0;
        wr_sel_nx   = '0;
        wr_dat_nx   = '0;

        case (win)
            FILL: begin
                fill_ack_nx = 1'b1;
                wr_nx       = 1'b1;
                tag_wr_nx   = 1'b1;
                tag_v_nx    = 1'b1;
                wr_way_nx   = WAYS'(1) << fill_way;
                wr_set_nx   = fill_set;
                wr_sel_nx   = '1;
                wr_dat_nx   = fill_dat;
            end
            STORE: begin
                st_ack_nx = 1'b1;
                if (hazard) begin
                    // Line was refilled under the store; requester must re-probe.
                    st_retry_nx = 1'b1;
                end else if (st_hit && st_acr[3]) begin
                    wr_nx     = 1'b1;
                    wr_way_nx = WAYS'(1) << st_way;
                    wr_set_nx = st_set;
                    wr_sel_nx = st_sel;
                    wr_dat_nx = st_dat;
                end
            end
            INV: begin
                if (!inv_all) begin
                    inv_ack_nx = 1'b1;
                    tag_wr_nx  = 1'b1;
                    wr_way_nx  = '1;
                    wr_set_nx  = inv_set;
                end
            end
            default: begin
                if (state == SWEEP) begin
                    sweep_adv  = 1'b1;
                    tag_wr_nx  = 1'b1;
                    wr_way_nx  = '1;
                    wr_set_nx  = sweep_set;
                    inv_ack_nx = sweep_last_c;
                end
            end
        endcase

        case (state)
            SWEEP: begin
                if (sweep_adv && sweep_last_c) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                case (win)
                    NONE:    state_nx = IDLE;
                    INV:     state_nx = inv_all ? SWEEP : GRANT;
                    default: state_nx = GRANT;
                endcase
            end
        endcase

        if (win == STORE) begin
            starve_nx = '0;
            hazard_nx = 1'b0;
        end else if (st_pend) begin
            if (!promote) begin
                starve_nx = starve_cnt + CW'(1);
            end
            if (win == FILL && fill_set == st_set && fill_way == st_way) begin
                hazard_nx = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            hazard     <= 1'b0;
            fill_ack   <= 1'b0;
            st_ack     <= 1'b0;
            st_retry   <= 1'b0;
            inv_ack    <= 1'b0;
            wr         <= 1'b0;
            tag_wr     <= 1'b0;
            tag_v      <= 1'b0;
            wr_way     <= '0;
            wr_set     <= '0;
            wr_sel     <= '0;
            wr_dat     <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            hazard     <= hazard_nx;
            fill_ack   <= fill_ack_nx;
            st_ack     <= st_ack_nx;
            st_retry   <= st_retry_nx;
            inv_ack    <= inv_ack_nx;
            wr         <= wr_nx;
            tag_wr     <= tag_wr_nx;
            tag_v      <= tag_v_nx;
            wr_way     <= wr_way_nx;
            wr_set     <= wr_set_nx;
            wr_sel     <= wr_sel_nx;
            wr_dat     <= wr_dat_nx;
        end
    end

endmodule

// File: tb/tb_thor2023_dcache_wr_arb.sv
// Scoreboard bench for the dcache write-port arbiter.
module tb_thor2023_dcache_wr_arb;

    localparam int unsigned WID    = 768;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned SETS   = 64;
    localparam int unsigned LOBIT  = 7;
    localparam int unsigned STARVE = 7;
    localparam int unsigned BW     = WID / 8;
    localparam int unsigned SW     = 6;

    typedef logic [WID-1:0] v_t;

    typedef struct {
        logic [WAYS-1:0] way;
        logic [SW-1:0]   set;
        logic [BW-1:0]   sel;
        logic [WID-1:0]  dat;
        logic            wr;
        logic            retry;
        logic            ack;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            fill_req = 1'b0;
    logic [31:0]     fill_adr = '0;
    logic [1:0]      fill_way = '0;
    logic [WID-1:0]  fill_dat = '0;
    logic            fill_ack;
    logic            st_req = 1'b0;
    logic [31:0]     st_adr = '0;
    logic [1:0]      st_way = '0;
    logic            st_hit = 1'b0;
    logic [3:0]      st_acr = '0;
    logic [BW-1:0]   st_sel = '0;
    logic [WID-1:0]  st_dat = '0;
    logic            st_ack;
    logic            st_retry;
    logic            inv_req = 1'b0;
    logic            inv_all = 1'b0;
    logic [31:0]     inv_adr = '0;
    logic            inv_ack;
    logic            wr;
    logic            tag_wr;
    logic            tag_v;
    logic [WAYS-1:0] wr_way;
    logic [SW-1:0]   wr_set;
    logic [BW-1:0]   wr_sel;
    logic [WID-1:0]  wr_dat;

    exp_t fq[$];
    exp_t sq[$];
    exp_t iq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    thor2023_dcache_wr_arb dut (
        .clk      (clk),
        .rst      (rst),
        .fill_req (fill_req),
        .fill_adr (fill_adr),
        .fill_way (fill_way),
        .fill_dat (fill_dat),
        .fill_ack (fill_ack),
        .st_req   (st_req),
        .st_adr   (st_adr),
        .st_way   (st_way),
        .st_hit   (st_hit),
        .st_acr   (st_acr),
        .st_sel   (st_sel),
        .st_dat   (st_dat),
        .st_ack   (st_ack),
        .st_retry (st_retry),
        .inv_req  (inv_req),
        .inv_all  (inv_all),
        .inv_adr  (inv_adr),
        .inv_ack  (inv_ack),
        .wr       (wr),
        .tag_wr   (tag_wr),
        .tag_v    (tag_v),
        .wr_way   (wr_way),
        .wr_set   (wr_set),
        .wr_sel   (wr_sel),
        .wr_dat   (wr_dat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input v_t got, input v_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WID-1:0] rand_line();
        logic [WID-1:0] r;
        for (int i = 0; i < WID / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_acks"}, v_t'({fill_ack, st_ack, st_retry, inv_ack}), v_t'(4'b0000));
        chk({tag, "_strb"}, v_t'({wr, tag_wr, tag_v}), v_t'(3'b000));
        chk({tag, "_way"}, v_t'(wr_way), v_t'(0));
        chk({tag, "_set"}, v_t'(wr_set), v_t'(0));
        chk({tag, "_sel"}, v_t'(wr_sel), v_t'(0));
        chk({tag, "_dat"}, wr_dat, v_t'(0));
    endtask

    // Monitor: every ack or tag strobe is matched against the per-source queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (fill_ack) begin
                if (fq.size() == 0) chk("fill_unexpected", v_t'(1), v_t'(0));
                else begin
                    e = fq.pop_front();
                    chk("fill_strb", v_t'({wr, tag_wr, tag_v}), v_t'(3'b111));
                    chk("fill_way", v_t'(wr_way), v_t'(e.way));
                    chk("fill_set", v_t'(wr_set), v_t'(e.set));
                    chk("fill_sel", v_t'(wr_sel), v_t'(e.sel));
                    chk("fill_dat", wr_dat, e.dat);
                end
            end
            if (st_ack) begin
                if (sq.size() == 0) chk("st_unexpected", v_t'(1), v_t'(0));
                else begin
                    e = sq.pop_front();
                    chk("st_retry", v_t'(st_retry), v_t'(e.retry));
                    chk("st_strb", v_t'({wr, tag_wr}), v_t'({e.wr, 1'b0}));
                    if (e.wr) begin
                        chk("st_way", v_t'(wr_way), v_t'(e.way));
                        chk("st_set", v_t'(wr_set), v_t'(e.set));
                        chk("st_sel", v_t'(wr_sel), v_t'(e.sel));
                        chk("st_dat", wr_dat, e.dat);
                    end
                end
            end
            if ((tag_wr && !fill_ack && !st_ack) || inv_ack) begin
                if (iq.size() == 0) chk("inv_unexpected", v_t'(1), v_t'(0));
                else begin
                    e = iq.pop_front();
                    chk("inv_strb", v_t'({wr, tag_wr, tag_v}), v_t'(3'b010));
                    chk("inv_way", v_t'(wr_way), v_t'(4'hF));
                    chk("inv_set", v_t'(wr_set), v_t'(e.set));
                    chk("inv_ack", v_t'(inv_ack), v_t'(e.ack));
                end
            end
            if (wr && !fill_ack && !st_ack) chk("stray_wr", v_t'(1), v_t'(0));
        end
    end

    task automatic do_fill(input logic [31:0] adr, input logic [1:0] way, input bit keep);
        exp_t e;
        int   n;
        bit   got;
        logic [WID-1:0] d;
        d       = rand_line();
        e.way   = WAYS'(1) << way;
        e.set   = adr[LOBIT +: SW];
        e.sel   = '1;
        e.dat   = d;
        e.wr    = 1'b1;
        e.retry = 1'b0;
        e.ack   = 1'b0;
        fq.push_back(e);
        fill_adr = adr;
        fill_way = way;
        fill_dat = d;
        fill_req = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = fill_ack;
        end
        chk("fill_done", v_t'(got), v_t'(1));
        @(posedge clk);
        #1;
        if (!keep) fill_req = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] adr, input logic [1:0] way, input logic hit,
                            input logic [3:0] acr, input logic [BW-1:0] sel, input logic retry,
                            output int lat);
        exp_t e;
        int   n;
        bit   got;
        logic [WID-1:0] d;
        d       = rand_line();
        e.way   = WAYS'(1) << way;
        e.set   = adr[LOBIT +: SW];
        e.sel   = sel;
        e.dat   = d;
        e.wr    = hit & acr[3] & ~retry;
        e.retry = retry;
        e.ack   = 1'b0;
        sq.push_back(e);
        st_adr = adr;
        st_way = way;
        st_hit = hit;
        st_acr = acr;
        st_sel = sel;
        st_dat = d;
        st_req = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = st_ack;
        end
        chk("st_done", v_t'(got), v_t'(1));
        lat = n - 1;
        @(posedge clk);
        #1;
        st_req = 1'b0;
    endtask

    task automatic push_sweep();
        exp_t e;
        e.way = '1; e.sel = '0; e.dat = '0; e.wr = 1'b0; e.retry = 1'b0;
        for (int s = 0; s < SETS; s++) begin
            e.set = SW'(s);
            e.ack = (s == SETS - 1);
            iq.push_back(e);
        end
    endtask

    task automatic do_inv(input logic all, input logic [31:0] adr);
        exp_t e;
        int   n;
        bit   got;
        if (all) push_sweep();
        else begin
            e.way = '1; e.sel = '0; e.dat = '0; e.wr = 1'b0; e.retry = 1'b0;
            e.set = adr[LOBIT +: SW];
            e.ack = 1'b1;
            iq.push_back(e);
        end
        inv_all = all;
        inv_adr = adr;
        inv_req = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = inv_ack;
        end
        chk("inv_done", v_t'(got), v_t'(1));
        @(posedge clk);
        #1;
        inv_req = 1'b0;
        inv_all = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  lat;
        int  n;
        bit  got;
        logic [WID-1:0] t;
        logic [BW-1:0]  rsel;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Single fill: set 0x21, way 2.
        do_fill(32'h0000_1080, 2'd2, 1'b0);

        // Store hit, cachable, sel 0x0F.
        do_store(32'h0000_2300, 2'd1, 1'b1, 4'b1000, BW'(8'h0F), 1'b0, lat);
        // Store to non-cachable line: ack only.
        t = rand_line(); rsel = t[BW-1:0];
        do_store(32'h0000_2300, 2'd1, 1'b1, 4'b0000, rsel, 1'b0, lat);
        // Store miss: ack only.
        do_store(32'h0000_2300, 2'd1, 1'b0, 4'b1000, rsel, 1'b0, lat);

        // Single-line invalidate of set 7.
        do_inv(1'b0, 32'h0000_0380);

        // Fill and store to the same set/way together: store must retry.
        fork
            do_fill(32'h0000_4A80, 2'd3, 1'b0);
            do_store(32'h0000_4A80, 2'd3, 1'b1, 4'b1000, rsel, 1'b1, lat);
        join
        // Hazard flag is gone: the re-probed store writes normally.
        do_store(32'h0000_4A80, 2'd3, 1'b1, 4'b1000, rsel, 1'b0, lat);

        // Fill held continuously while a store waits.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    do_fill(32'(i + 1) << LOBIT, 2'(i), (i < 9));
            end
            begin
                @(posedge clk);
                #1;
                do_store(32'h0000_1400, 2'd0, 1'b1, 4'b1000, rsel, 1'b0, lat);
                chk("st_starve_lat", v_t'(lat <= int'(STARVE) + 2), v_t'(1));
            end
        join

        // Full sweep.
        do_inv(1'b1, 32'h0);

        // Full sweep with a fill injected part-way through.
        fork
            do_inv(1'b1, 32'h0);
            begin
                repeat (15) @(posedge clk);
                #1;
                do_fill(32'h0000_0D80, 2'd1, 1'b0);
            end
        join

        // Reset in the middle of a sweep, right after set 20 is written.
        push_sweep();
        inv_all = 1'b1;
        inv_req = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = tag_wr && (wr_set == SW'(20));
        end
        chk("sweep_reach20", v_t'(got), v_t'(1));
        #1;
        rst = 1'b0;
        iq.delete();
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("mid_rst");
        @(posedge clk);
        #1;
        inv_req = 1'b0;
        inv_all = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        // Counter must restart at set 0.
        do_inv(1'b1, 32'h0);

        repeat (3) @(posedge clk);
        chk("fq_empty", v_t'(fq.size()), v_t'(0));
        chk("sq_empty", v_t'(sq.size()), v_t'(0));
        chk("iq_empty", v_t'(iq.size()), v_t'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
